hsv2rgb: RTL and testbench

//  Pipelined HSV->RGB colour-space converter; inverse of rgb2hsv in the video chain.

---
 rtl/hsv2rgb_if.sv | 29 ++
 rtl/hsv2rgb.sv | 156 +++++++++++++++
 tb/tb_hsv2rgb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/hsv2rgb_if.sv
// Pixel-stream bundle for the HSV->RGB converter: clock enable, the HSV pixel
// with its syncs on the way in, and the RGB pixel with delayed syncs on the way out.
interface hsv2rgb_if;
  logic       ce;
  logic [7:0] H;
  logic [7:0] S;
  logic [7:0] V;
  logic       in_hsync;
  logic       in_vsync;
  logic       in_de;
  logic [7:0] R;
  logic [7:0] G;
  logic [7:0] B;
  logic       out_hsync;
  logic       out_vsync;
  logic       out_de;

  // Pixel source / sink side (upstream HSV path and downstream HDMI stage).
  modport master (
    output ce, H, S, V, in_hsync, in_vsync, in_de,
    input  R, G, B, out_hsync, out_vsync, out_de
  );

  // Converter side.
  modport slave (
    input  ce, H, S, V, in_hsync, in_vsync, in_de,
    output R, G, B, out_hsync, out_vsync, out_de
  );
endinterface

// File: rtl/hsv2rgb.sv
// Four-stage pipelined HSV->RGB converter. Hue uses a 256-code circle split
// into six sectors; all arithmetic is unsigned with truncating >>8. Syncs and
// data enable ride alongside the pixel so the output stays aligned. Every
// register advances only on ce and clears asynchronously on rst.
module hsv2rgb #(
  parameter bit BLANK_ZERO = 1'b1
) (
  input  logic     clk,
  input  logic     rst,
  hsv2rgb_if.slave px
);

  localparam int DATA_W = 8;

  // (x * y) >> 8 with y up to 256; the product always fits 16 bits.
  function automatic logic [DATA_W-1:0] mul_shr(input logic [DATA_W-1:0] x,
                                                input logic [DATA_W:0]   y);
    logic [2*DATA_W-1:0] prod;
    prod = {{DATA_W{1'b0}}, x} * {{(DATA_W-1){1'b0}}, y};
    return DATA_W'(prod >> DATA_W);
  endfunction

  // 256 - x as a 9-bit operand.
  function automatic logic [DATA_W:0] compl256(input logic [DATA_W-1:0] x);
    return 9'd256 - {1'b0, x};
  endfunction

  // Sector-based channel selection; sectors 6/7 cannot occur and give black.
  function automatic logic [3*DATA_W-1:0] sector_mux(input logic [2:0]        sec,
                                                     input logic [DATA_W-1:0] v,
                                                     input logic [DATA_W-1:0] p,
                                                     input logic [DATA_W-1:0] q,
                                                     input logic [DATA_W-1:0] t);
    logic [3*DATA_W-1:0] rgb;
    case (sec)
      3'd0:    rgb = {v, t, p};
      3'd1:    rgb = {q, v, p};
      3'd2:    rgb = {p, v, t};
      3'd3:    rgb = {p, q, v};
      3'd4:    rgb = {t, p, v};
      3'd5:    rgb = {v, p, q};
      default: rgb = '0;
    endcase
    return rgb;
  endfunction

  logic [10:0]         h6_p0;

  logic [2:0]          sector_p1;
  logic [DATA_W-1:0]   f_p1, s_p1, v_p1;
  logic                vld_p1, hs_p1, vs_p1;

  logic [2:0]          sector_p2;
  logic [DATA_W-1:0]   a_p2, b_p2, s_p2, v_p2;
  logic                vld_p2, hs_p2, vs_p2;

  logic [2:0]          sector_p3;
  logic [DATA_W-1:0]   p_p3, q_p3, t_p3, v_p3;
  logic                vld_p3, hs_p3, vs_p3;

  logic [3*DATA_W-1:0] rgb_p4;
  logic                vld_p4, hs_p4, vs_p4;

  assign h6_p0 = 11'(px.H) * 11'd6;

  // Stage 1: scale hue by six, split into sector and fractional position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sector_p1 <= '0;
      f_p1      <= '0;
      s_p1      <= '0;
      v_p1      <= '0;
      vld_p1    <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
    end else if (px.ce) begin
      sector_p1 <= h6_p0[10:8];
      f_p1      <= h6_p0[7:0];
      s_p1      <= px.S;
      v_p1      <= px.V;
      vld_p1    <= px.in_de;
      hs_p1     <= px.in_hsync;
      vs_p1     <= px.in_vsync;
    end
  end

  // Stage 2: saturation weighted by the rising and falling fraction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sector_p2 <= '0;
      a_p2      <= '0;
      b_p2      <= '0;
      s_p2      <= '0;
      v_p2      <= '0;
      vld_p2    <= 1'b0;
      hs_p2     <= 1'b0;
      vs_p2     <= 1'b0;
    end else if (px.ce) begin
      sector_p2 <= sector_p1;
      a_p2      <= mul_shr(s_p1, {1'b0, f_p1});
      b_p2      <= mul_shr(s_p1, compl256(f_p1));
      s_p2      <= s_p1;
      v_p2      <= v_p1;
      vld_p2    <= vld_p1;
      hs_p2     <= hs_p1;
      vs_p2     <= vs_p1;
    end
  end

  // Stage 3: the three non-peak channel levels p, q, t (each bounded by V).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sector_p3 <= '0;
      p_p3      <= '0;
      q_p3      <= '0;
      t_p3      <= '0;
      v_p3      <= '0;
      vld_p3    <= 1'b0;
      hs_p3     <= 1'b0;
      vs_p3     <= 1'b0;
    end else if (px.ce) begin
      sector_p3 <= sector_p2;
      p_p3      <= mul_shr(v_p2, compl256(s_p2));
      q_p3      <= mul_shr(v_p2, compl256(a_p2));
      t_p3      <= mul_shr(v_p2, compl256(b_p2));
      v_p3      <= v_p2;
      vld_p3    <= vld_p2;
      hs_p3     <= hs_p2;
      vs_p3     <= vs_p2;
    end
  end

  // Stage 4: route levels to R/G/B by sector, blank outside active video.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_p4 <= '0;
      vld_p4 <= 1'b0;
      hs_p4  <= 1'b0;
      vs_p4  <= 1'b0;
    end else if (px.ce) begin
      rgb_p4 <= (BLANK_ZERO && !vld_p3) ? '0
                                        : sector_mux(sector_p3, v_p3, p_p3, q_p3, t_p3);
      vld_p4 <= vld_p3;
      hs_p4  <= hs_p3;
      vs_p4  <= vs_p3;
    end
  end

  assign px.R         = rgb_p4[23:16];
  assign px.G         = rgb_p4[15:8];
  assign px.B         = rgb_p4[7:0];
  assign px.out_de    = vld_p4;
  assign px.out_hsync = hs_p4;
  assign px.out_vsync = vs_p4;

endmodule

// File: tb/tb_hsv2rgb.sv
// Bench for hsv2rgb: two instances (blanking on / off) share one stimulus.
// A directed table covers gray, black, primaries and blanking; hand sequences
// cover sync alignment and asynchronous reset; a randomized stream with
// stalled and toggling ce is checked every cycle against a reference model.
module tb_hsv2rgb;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b1;
  logic [7:0] h = '0, s = '0, v = '0;
  logic       hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic       chk_on = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hsv2rgb_if ifa();
  hsv2rgb_if ifb();

  assign ifa.ce = ce;  assign ifa.H = h;  assign ifa.S = s;  assign ifa.V = v;
  assign ifa.in_hsync = hs;  assign ifa.in_vsync = vs;  assign ifa.in_de = de;
  assign ifb.ce = ce;  assign ifb.H = h;  assign ifb.S = s;  assign ifb.V = v;
  assign ifb.in_hsync = hs;  assign ifb.in_vsync = vs;  assign ifb.in_de = de;

  hsv2rgb #(.BLANK_ZERO(1'b1)) dut_a (.clk(clk), .rst(rst), .px(ifa));
  hsv2rgb #(.BLANK_ZERO(1'b0)) dut_b (.clk(clk), .rst(rst), .px(ifb));

  // Reference conversion straight from the hue-sector formulas.
  function automatic logic [23:0] ref_rgb(input int hh, input int ss, input int vv);
    int h6, sec, f, a, bw, p, q, t, r, g, bl;
    h6  = hh * 6;
    sec = h6 / 256;
    f   = h6 % 256;
    a   = (ss * f) / 256;
    bw  = (ss * (256 - f)) / 256;
    p   = (vv * (256 - ss)) / 256;
    q   = (vv * (256 - a)) / 256;
    t   = (vv * (256 - bw)) / 256;
    case (sec)
      0: begin r = vv; g = t;  bl = p;  end
      1: begin r = q;  g = vv; bl = p;  end
      2: begin r = p;  g = vv; bl = t;  end
      3: begin r = p;  g = q;  bl = vv; end
      4: begin r = t;  g = p;  bl = vv; end
      5: begin r = vv; g = p;  bl = q;  end
      default: begin r = 0; g = 0; bl = 0; end
    endcase
    return {8'(r), 8'(g), 8'(bl)};
  endfunction

  typedef struct packed {
    logic [23:0] rgb;
    logic        hs;
    logic        vs;
    logic        de;
  } pix_t;

  // Ideal 4-sample delay line, advanced once per enabled clock.
  pix_t mp [4] = '{default: '0};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mp[i] <= '0;
    end else if (ce) begin
      mp[0] <= {ref_rgb(int'(h), int'(s), int'(v)), hs, vs, de};
      for (int i = 1; i < 4; i++) mp[i] <= mp[i-1];
    end
  end

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] rgb_a();
    return {ifa.R, ifa.G, ifa.B};
  endfunction
  function automatic logic [23:0] rgb_b();
    return {ifb.R, ifb.G, ifb.B};
  endfunction
  function automatic logic [23:0] syn_a();
    return {21'd0, ifa.out_hsync, ifa.out_vsync, ifa.out_de};
  endfunction
  function automatic logic [23:0] syn_b();
    return {21'd0, ifb.out_hsync, ifb.out_vsync, ifb.out_de};
  endfunction

  // Continuous scoreboard, sampled away from the rising edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("stream_a_rgb",  rgb_a(), mp[3].de ? mp[3].rgb : 24'd0);
      chk("stream_b_rgb",  rgb_b(), mp[3].rgb);
      chk("stream_a_sync", syn_a(), {21'd0, mp[3].hs, mp[3].vs, mp[3].de});
      chk("stream_b_sync", syn_b(), {21'd0, mp[3].hs, mp[3].vs, mp[3].de});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pixel(input int de_pct);
    int sel;
    h   = 8'($urandom);
    sel = $urandom_range(0, 7);
    s   = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
    sel = $urandom_range(0, 7);
    v   = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
    hs  = ($urandom_range(0, 9) == 0);
    vs  = ($urandom_range(0, 19) == 0);
    de  = ($urandom_range(0, 99) < de_pct);
  endtask

  typedef struct {
    string       nm;
    logic [7:0]  h, s, v;
    logic        de;
    logic [23:0] exp_a;
    logic [23:0] exp_b;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tbl[0] = '{"gray200",    8'd37,  8'd0,   8'd200, 1'b1, 24'hC8C8C8, 24'hC8C8C8};
    tbl[1] = '{"black",      8'd37,  8'd0,   8'd0,   1'b1, 24'h000000, 24'h000000};
    tbl[2] = '{"red_h0",     8'd0,   8'd255, 8'd255, 1'b1, 24'hFF0000, 24'hFF0000};
    tbl[3] = '{"h43",        8'd43,  8'd255, 8'd255, 1'b1, 24'hFEFF00, 24'hFEFF00};
    tbl[4] = '{"h85",        8'd85,  8'd255, 8'd255, 1'b1, 24'h02FF00, 24'h02FF00};
    tbl[5] = '{"cyan_h128",  8'd128, 8'd255, 8'd255, 1'b1, 24'h00FFFF, 24'h00FFFF};
    tbl[6] = '{"h255_sec5",  8'd255, 8'd255, 8'd255, 1'b1, 24'hFF0006, 24'hFF0006};
    tbl[7] = '{"blank_de0",  8'd0,   8'd255, 8'd255, 1'b0, 24'h000000, 24'hFF0000};
    tbl[8] = '{"v0_sat",     8'd200, 8'd255, 8'd0,   1'b1, 24'h000000, 24'h000000};

    // Reset asserted before any clock edge.
    #1 rst = 1'b1;
    #2;
    chk("reset_a_rgb",  rgb_a(), 24'd0);
    chk("reset_a_sync", syn_a(), 24'd0);
    chk("reset_b_rgb",  rgb_b(), 24'd0);
    chk_on = 1'b1;
    h = 8'd10; s = 8'd100; v = 8'd100; de = 1'b1; hs = 1'b1; vs = 1'b1;
    step(); step();
    chk("reset_hold_a", {rgb_a()[23:3], syn_a()[2:0]}, 24'd0);
    @(negedge clk); #2 rst = 1'b0;

    // Directed vectors: one pixel in, three idle pixels, result on the 4th edge.
    for (int i = 0; i < 9; i++) begin
      step();
      h = tbl[i].h; s = tbl[i].s; v = tbl[i].v; de = tbl[i].de; hs = 1'b0; vs = 1'b0;
      step();
      rand_pixel(0);
      hs = 1'b0; vs = 1'b0;
      step(); step(); step();
      chk({tbl[i].nm, "_a"}, rgb_a(), tbl[i].exp_a);
      chk({tbl[i].nm, "_b"}, rgb_b(), tbl[i].exp_b);
      chk({tbl[i].nm, "_de"}, syn_a(), {23'd0, tbl[i].de});
    end

    // Sync alignment: single-pixel de with coincident hsync/vsync pulse.
    step();
    h = 8'd0; s = 8'd0; v = 8'd77; de = 1'b1; hs = 1'b1; vs = 1'b1;
    step();
    de = 1'b0; hs = 1'b0; vs = 1'b0;
    step(); step();
    chk("align_pre", syn_a(), 24'd0);
    step();
    chk("align_sync", syn_a(), 24'd7);
    chk("align_pix",  rgb_a(), 24'h4D4D4D);
    step();
    chk("align_post", syn_a(), 24'd0);

    // Asynchronous reset in the middle of an active line.
    for (int i = 0; i < 6; i++) begin
      step();
      rand_pixel(100);
      hs = 1'b1;
    end
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("midrst_a_rgb",  rgb_a(), 24'd0);
    chk("midrst_a_sync", syn_a(), 24'd0);
    chk("midrst_b_rgb",  rgb_b(), 24'd0);
    chk("midrst_b_sync", syn_b(), 24'd0);
    step(); step();
    @(negedge clk); #2 rst = 1'b0;
    h = 8'd0; s = 8'd255; v = 8'd255; de = 1'b1; hs = 1'b0; vs = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      step();
      if (k < 4) chk("midrst_early_de", syn_a(), 24'd0);
    end
    chk("midrst_first_de",  syn_a(), 24'd1);
    chk("midrst_first_pix", rgb_a(), 24'hFF0000);

    // ce stalled pseudo-randomly about half the time.
    for (int i = 0; i < 400; i++) begin
      step();
      ce = 1'($urandom_range(0, 1));
      rand_pixel(75);
    end
    // ce toggling every cycle.
    for (int i = 0; i < 60; i++) begin
      step();
      ce = ~ce;
      rand_pixel(75);
    end
    // Continuous stream with ce held high.
    for (int i = 0; i < 300; i++) begin
      step();
      ce = 1'b1;
      rand_pixel(80);
    end
    step(); step(); step(); step(); step();

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
